// File: rtl/seq_mul_param.sv
// Sequential MSB-first shift-add multiplier: one multiplier bit per clock, W steps per product.
// Supports unsigned or two's-complement operands, selected per operation.
module seq_mul_param #(
    parameter int W = 8
) (
    input  logic           ck,
    input  logic           rst,
    input  logic           start,
    input  logic           sgn,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic [2*W-1:0] O,
    output logic           busy,
    output logic           fin
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   ain_q, ain_d;
    logic [W-1:0]   bin_q, bin_d;
    logic           sg_q, sg_d;
    logic [2*W-1:0] o_q, o_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           fin_q, fin_d;
    logic [2*W-1:0] pp;

    always_comb begin
        state_d = state_q;
        ain_d   = ain_q;
        bin_d   = bin_q;
        sg_d    = sg_q;
        o_d     = o_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        fin_d   = 1'b0;

        pp = '0;
        if (bin_q[cnt_q])
            pp = sg_q ? {{W{ain_q[W-1]}}, ain_q} : {{W{1'b0}}, ain_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    ain_d   = A;
                    bin_d   = B;
                    sg_d    = sgn;
                    o_d     = '0;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_TOP;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The top multiplier bit carries negative weight in signed mode.
                if (sg_q && (cnt_q == CNT_TOP))
                    o_d = (o_q << 1) - pp;
                else
                    o_d = (o_q << 1) + pp;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    fin_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ain_q   <= '0;
            bin_q   <= '0;
            sg_q    <= 1'b0;
            o_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ain_q   <= ain_d;
            bin_q   <= bin_d;
            sg_q    <= sg_d;
            o_q     <= o_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
        end
    end

    assign O    = o_q;
    assign busy = busy_q;
    assign fin  = fin_q;

endmodule

// File: tb/tb_seq_mul_param.sv
// Scoreboard bench for seq_mul_param at W=8 and W=4: drivers push reference products,
// monitors pop and compare on every fin pulse.
module tb_seq_mul_param;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] o8;
    logic        busy8, fin8;

    logic        start4 = 1'b0, sgn4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  o4;
    logic        busy4, fin4;

    int checks = 0;
    int errors = 0;

    logic [15:0] q8[$];
    logic [7:0]  q4[$];

    seq_mul_param #(.W(8)) dut8 (
        .ck(clk), .rst(rst), .start(start8), .sgn(sgn8),
        .A(a8), .B(b8), .O(o8), .busy(busy8), .fin(fin8)
    );

    seq_mul_param #(.W(4)) dut4 (
        .ck(clk), .rst(rst), .start(start4), .sgn(sgn4),
        .A(a4), .B(b4), .O(o4), .busy(busy4), .fin(fin4)
    );

    always #5 clk = ~clk;

    // Reference: interpret operands as integers, multiply, keep the low 2*w bits.
    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input logic s);
        longint av, bv, p, mask;
        av = longint'(a);
        bv = longint'(b);
        if (s && a[w-1]) av = av - (longint'(1) << w);
        if (s && b[w-1]) bv = bv - (longint'(1) << w);
        mask = (longint'(1) << (2 * w)) - 1;
        p = (av * bv) & mask;
        return p[31:0];
    endfunction

    // ---------------- monitors ----------------
    int          run8 = 0;
    logic        fin8_prev = 1'b0;
    logic [15:0] last8 = '0;
    logic [15:0] exp8;

    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (o8 !== 16'h0 || busy8 !== 1'b0 || fin8 !== 1'b0) begin
                errors++;
                $display("FAIL reset8: O=%h busy=%b fin=%b required O=0000 busy=0 fin=0", o8, busy8, fin8);
            end
            run8 = 0; last8 = '0; fin8_prev = 1'b0;
        end else begin
            if (busy8) run8++;
            if (fin8) begin
                checks++;
                if (fin8_prev) begin
                    errors++;
                    $display("FAIL fin8_width: fin high on consecutive cycles, required one-cycle pulse");
                end
                checks++;
                if (q8.size() == 0) begin
                    errors++;
                    $display("FAIL fin8_unexpected: fin with O=%h but no operation outstanding", o8);
                end else begin
                    exp8 = q8.pop_front();
                    checks++;
                    if (o8 !== exp8) begin
                        errors++;
                        $display("FAIL product8: O=%h required %h", o8, exp8);
                    end
                    checks++;
                    if (run8 != 8) begin
                        errors++;
                        $display("FAIL busy8_len: busy cycles=%0d required 8", run8);
                    end
                end
                run8 = 0;
                last8 = o8;
            end else if (!busy8) begin
                checks++;
                if (o8 !== last8) begin
                    errors++;
                    $display("FAIL hold8: idle O=%h required held %h", o8, last8);
                end
            end
            fin8_prev = fin8;
        end
    end

    int          run4 = 0;
    logic        fin4_prev = 1'b0;
    logic [7:0]  last4 = '0;
    logic [7:0]  exp4;

    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (o4 !== 8'h0 || busy4 !== 1'b0 || fin4 !== 1'b0) begin
                errors++;
                $display("FAIL reset4: O=%h busy=%b fin=%b required O=00 busy=0 fin=0", o4, busy4, fin4);
            end
            run4 = 0; last4 = '0; fin4_prev = 1'b0;
        end else begin
            if (busy4) run4++;
            if (fin4) begin
                checks++;
                if (fin4_prev) begin
                    errors++;
                    $display("FAIL fin4_width: fin high on consecutive cycles, required one-cycle pulse");
                end
                checks++;
                if (q4.size() == 0) begin
                    errors++;
                    $display("FAIL fin4_unexpected: fin with O=%h but no operation outstanding", o4);
                end else begin
                    exp4 = q4.pop_front();
                    checks++;
                    if (o4 !== exp4) begin
                        errors++;
                        $display("FAIL product4: O=%h required %h", o4, exp4);
                    end
                    checks++;
                    if (run4 != 4) begin
                        errors++;
                        $display("FAIL busy4_len: busy cycles=%0d required 4", run4);
                    end
                end
                run4 = 0;
                last4 = o4;
            end else if (!busy4) begin
                checks++;
                if (o4 !== last4) begin
                    errors++;
                    $display("FAIL hold4: idle O=%h required held %h", o4, last4);
                end
            end
            fin4_prev = fin4;
        end
    end

    // ---------------- drivers ----------------
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int n = 0;
        @(negedge clk);
        while (busy8 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (busy8) begin
            errors++;
            $display("FAIL idle8_timeout: busy=%b required 0 within 100 cycles", busy8);
            return;
        end
        a8 = a; b8 = b; sgn8 = s; start8 = 1'b1;
        q8.push_back(ref_mul(8, {8'h0, a}, {8'h0, b}, s)[15:0]);
        $display("op8  A=%h B=%h sgn=%b", a, b, s);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s);
        int n = 0;
        @(negedge clk);
        while (busy4 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (busy4) begin
            errors++;
            $display("FAIL idle4_timeout: busy=%b required 0 within 100 cycles", busy4);
            return;
        end
        a4 = a; b4 = b; sgn4 = s; start4 = 1'b1;
        q4.push_back(ref_mul(4, {12'h0, a}, {12'h0, b}, s)[7:0]);
        $display("op4  A=%h B=%h sgn=%b", a, b, s);
        @(posedge clk);
        #1;
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); sgn4 = 1'($urandom);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q8.size() != 0 || q4.size() != 0) && n < budget) begin
            @(negedge clk); n++;
        end
        checks++;
        if (q8.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: outstanding w8=%0d w4=%0d required 0", q8.size(), q4.size());
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        // Directed W=8 cases
        op8(8'd200, 8'd150, 1'b0);
        repeat (4) @(negedge clk);
        op8(8'hFF, 8'hFF, 1'b0);
        op8(8'h00, 8'd173, 1'b0);
        op8(8'hFD, 8'h05, 1'b1);
        op8(8'h80, 8'h80, 1'b1);
        op8(8'h7F, 8'h80, 1'b1);
        drain(50);

        // Start raised mid-run is ignored, then accepted in the fin cycle
        op8(8'd6, 8'd7, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        a8 = 8'd9; b8 = 8'd9; sgn8 = 1'b0; start8 = 1'b1;
        begin
            int n = 0;
            @(negedge clk);
            while (!fin8 && n < 20) begin @(negedge clk); n++; end
            checks++;
            if (!fin8) begin
                errors++;
                $display("FAIL fin_wait: no fin within 20 cycles");
            end else begin
                q8.push_back(16'(ref_mul(8, 16'd9, 16'd9, 1'b0)));
                $display("op8  A=09 B=09 sgn=0 (fin-cycle start)");
            end
            @(posedge clk);
            #1 start8 = 1'b0;
        end
        drain(50);

        // Asynchronous abort mid-operation
        op8(8'd100, 8'd100, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (o8 !== 16'h0 || busy8 !== 1'b0 || fin8 !== 1'b0) begin
            errors++;
            $display("FAIL async_abort: O=%h busy=%b fin=%b required 0 0 0", o8, busy8, fin8);
        end
        q8.delete();
        $display("abort8 rst asserted mid-operation");
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (15) @(negedge clk);
        op8(8'd100, 8'd100, 1'b0);
        drain(50);

        // Randomized W=8 with back-to-back and idle gaps
        for (int i = 0; i < 40; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        drain(100);

        // W=4 directed and randomized
        op4(4'hF, 4'hF, 1'b0);
        op4(4'hF, 4'h7, 1'b1);
        op4(4'h8, 4'h8, 1'b1);
        for (int i = 0; i < 30; i++) begin
            op4(4'($urandom), 4'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain(100);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
